// File: rtl/audio_pkg.sv
// Shared audio definitions: controller state encoding, default PCM/PDM
// geometry and the midscale helper used by the playback and capture paths.
package audio_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pdm_state_e;

    localparam int PCM_WIDTH   = 16;
    localparam int PDM_CLK_DIV = 42;
    localparam int PDM_OSR     = 64;

    // Offset-binary zero level for a sample of the given width.
    function automatic logic [31:0] midscale(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power
// of two so the pointers wrap on their own.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Sample storage, cleared on reset so no stale data can ever be replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/audio_pdm_tx.sv
// PCM-to-PDM playback path: sample FIFO, bit-clock divider, oversampling
// counter and first-order sigma-delta modulator driving AUD_PWM/AUD_SD.
module audio_pdm_tx
    import audio_pkg::*;
#(
    parameter int WIDTH      = PCM_WIDTH,
    parameter int CLK_DIV    = PDM_CLK_DIV,
    parameter int OSR        = PDM_OSR,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             AUD_PWM,
    output logic             AUD_SD,
    output logic             underrun
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SAMP_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WIDTH-1:0] MID_C = WIDTH'(midscale(WIDTH));

    pdm_state_e        state_r;
    pdm_state_e        state_nxt_s;
    logic [DIV_W-1:0]  div_cnt_r;
    logic [SAMP_W-1:0] samp_cnt_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  cur_r;
    logic              pwm_r;
    logic              sd_r;
    logic              underrun_r;
    logic [WIDTH:0]    sum_s;
    logic              run_s;
    logic              tick_s;
    logic              slot_s;
    logic              push_s;
    logic              pop_s;
    logic [WIDTH-1:0]  fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [FCW-1:0]    fifo_count_s;

    // Dropping enable aborts the current bit in the very next cycle.
    assign run_s   = (state_r == RUN) && enable;
    assign tick_s  = run_s && (div_cnt_r == DIV_W'(CLK_DIV - 1));
    assign slot_s  = tick_s && (samp_cnt_r == SAMP_W'(OSR - 1));
    assign pop_s   = slot_s && !fifo_empty_s;
    assign push_s  = s_valid && !fifo_full_s;
    assign s_ready = (fifo_count_s != FCW'(FIFO_DEPTH));
    assign sum_s   = {1'b0, acc_r} + {1'b0, cur_r};

    assign AUD_PWM  = pwm_r;
    assign AUD_SD   = sd_r;
    assign underrun = underrun_r;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (s_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: enable alone selects between idle and modulating.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (enable) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Divider, oversampling counter and modulator; idle reloads everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r  <= DIV_W'(0);
            samp_cnt_r <= SAMP_W'(0);
            acc_r      <= WIDTH'(0);
            cur_r      <= MID_C;
            pwm_r      <= 1'b0;
            sd_r       <= 1'b0;
            underrun_r <= 1'b0;
        end else if (!run_s) begin
            div_cnt_r  <= DIV_W'(0);
            samp_cnt_r <= SAMP_W'(0);
            acc_r      <= WIDTH'(0);
            cur_r      <= MID_C;
            pwm_r      <= 1'b0;
            sd_r       <= (state_nxt_s == RUN);
            underrun_r <= 1'b0;
        end else begin
            sd_r <= 1'b1;
            if (tick_s) begin
                div_cnt_r <= DIV_W'(0);
                pwm_r     <= sum_s[WIDTH];
                acc_r     <= sum_s[WIDTH-1:0];
                if (slot_s) begin
                    samp_cnt_r <= SAMP_W'(0);
                    // An empty slot keeps replaying the previous sample.
                    if (!fifo_empty_s) begin
                        cur_r <= fifo_rdata_s;
                    end else begin
                        underrun_r <= 1'b1;
                    end
                end else begin
                    samp_cnt_r <= samp_cnt_r + SAMP_W'(1);
                end
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_audio_pdm_tx.sv
// Self-checking bench for audio_pdm_tx: a time-based behavioural model checked
// every cycle, plus hand-computed expectations for densities and timing.
module tb_audio_pdm_tx;

    localparam int CLK_DIV = 42;
    localparam int OSR     = 64;
    localparam int DEPTH   = 4;
    localparam int MID     = 32768;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] s_data = 16'h0000;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        AUD_PWM;
    logic        AUD_SD;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int rc       = 0;
    logic bits [0:255];

    audio_pdm_tx #(
        .WIDTH      (16),
        .CLK_DIV    (CLK_DIV),
        .OSR        (OSR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .AUD_PWM  (AUD_PWM),
        .AUD_SD   (AUD_SD),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: time spent in RUN decides bit boundaries and sample slots.
    int  m_q[$];
    bit  m_run = 1'b0;
    int  m_t = 0;
    int  m_acc = 0;
    int  m_cur = MID;
    int  m_total = 0;
    bit  m_pwm = 1'b0;
    bit  m_und = 1'b0;
    bit  m_room = 1'b1;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_q.delete();
            m_run = 1'b0; m_t = 0; m_acc = 0; m_cur = MID; m_pwm = 1'b0; m_und = 1'b0;
        end else begin
            m_room = (m_q.size() < DEPTH);
            if (m_run && enable) begin
                m_t++;
                if (m_t % CLK_DIV == 0) begin
                    m_total = m_acc + m_cur;
                    m_pwm   = (m_total >= 65536);
                    m_acc   = m_total % 65536;
                    if ((m_t / CLK_DIV) % OSR == 0) begin
                        if (m_q.size() > 0) m_cur = m_q.pop_front();
                        else m_und = 1'b1;
                    end
                end
            end else begin
                m_run = enable; m_t = 0; m_acc = 0; m_cur = MID; m_pwm = 1'b0; m_und = 1'b0;
            end
            if (s_valid && m_room) m_q.push_back(int'(s_data));
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        chk("pwm",      int'(AUD_PWM),  int'(m_pwm));
        chk("sd",       int'(AUD_SD),   int'(m_run));
        chk("s_ready",  int'(s_ready),  int'(m_q.size() < DEPTH));
        chk("underrun", int'(underrun), int'(m_und));
    end

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        rc++;
    endtask

    task automatic go();
        enable = 1'b1;
        rc = 0;
    endtask

    task automatic stop();
        enable = 1'b0;
        step();
    endtask

    task automatic push(input logic [15:0] d);
        s_data = d;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Bit k is visible from negedge 42k+43 to 42k+84 after enable; sample mid-cell.
    task automatic collect(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            while (rc < CLK_DIV * k + 63) step();
            bits[k] = AUD_PWM;
        end
    endtask

    function automatic int ones(input int first);
        int n = 0;
        for (int k = first; k < first + OSR; k++) n += int'(bits[k]);
        return n;
    endfunction

    int errs;
    int acc_n;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;

        repeat (10000) @(negedge clk);
        chk("idle_sd", int'(AUD_SD), 0);
        chk("idle_ready", int'(s_ready), 1);

        repeat (4) push(16'h8000);
        go();
        step();
        chk("sd_rise", int'(AUD_SD), 1);
        collect(0, 255);
        errs = 0;
        for (int k = 0; k < 256; k++) if (int'(bits[k]) != (k % 2)) errs++;
        chk("mid_alternate_errs", errs, 0);
        chk("mid_underrun", int'(underrun), 0);
        stop();
        chk("stop_sd", int'(AUD_SD), 0);

        push(16'h0000);
        push(16'hFFFF);
        push(16'h4000);
        go();
        collect(0, 255);
        chk("ones_midscale", ones(0), 32);
        chk("ones_0000", ones(64), 0);
        chk("ones_ffff", ones(128), 63);
        chk("ones_4000", ones(192), 16);
        chk("ext_underrun", int'(underrun), 1);
        stop();
        chk("ext_underrun_clear", int'(underrun), 0);

        acc_n = 0;
        s_data = 16'h1000;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (s_ready) begin
                acc_n++;
                step();
                s_data = s_data + 16'h0001;
            end else begin
                step();
            end
        end
        chk("bp_accepted", acc_n, 4);
        chk("bp_ready_low", int'(s_ready), 0);
        go();
        while (s_ready !== 1'b1 && rc < 4000) step();
        chk("bp_ready_rise_clk", rc, 2689);
        s_valid = 1'b0;
        stop();

        go();
        while (rc < 100) step();
        chk("abort_pwm_before", int'(AUD_PWM), 1);
        stop();
        chk("abort_pwm", int'(AUD_PWM), 0);
        chk("abort_sd", int'(AUD_SD), 0);

        s_data = 16'h3000;
        s_valid = 1'b1;
        go();
        while (rc < 3000) step();
        chk("full_before_reset", int'(s_ready), 0);
        chk("sd_before_reset", int'(AUD_SD), 1);
        reset = 1'b0;
        enable = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("rst_sd", int'(AUD_SD), 0);
        chk("rst_pwm", int'(AUD_PWM), 0);
        chk("rst_ready", int'(s_ready), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        push(16'hC000);
        go();
        while (rc < 5376) step();
        chk("und_before", int'(underrun), 0);
        step();
        chk("und_set", int'(underrun), 1);
        collect(128, 191);
        chk("und_replay_ones", ones(128), 48);
        stop();
        chk("und_clear", int'(underrun), 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
